// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate controller: gate state encodings
// and the role constants used to specialise each gate instance.
package parking_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_DENY    = 3'd2;
  localparam logic [2:0] ST_OPEN    = 3'd3;
  localparam logic [2:0] ST_PASSING = 3'd4;
  localparam logic [2:0] ST_CLOSE   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_CHECK   = ST_CHECK,
    S_DENY    = ST_DENY,
    S_OPEN    = ST_OPEN,
    S_PASSING = ST_PASSING,
    S_CLOSE   = ST_CLOSE
  } gate_state_e;

  localparam bit GATE_ENTRY = 1'b1;
  localparam bit GATE_EXIT  = 1'b0;

endpackage

// File: rtl/parking_gate_fsm.sv
// One barrier gate: input synchronizers, gate FSM and open timeout counter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | barrier down, waiting for a rising arrive
// CHECK   | one cycle; entry gate inspects the vacancy flag
// DENY    | entry only: lot full for this car class, polling vacancy
// OPEN    | barrier up, waiting for pass or the open timeout
// PASSING | barrier up, car on the pass loop; event on pass falling
// CLOSE   | barrier down, waiting for both loops to clear
module parking_gate_fsm
  import parking_pkg::*;
#(
  parameter bit IS_ENTRY     = GATE_ENTRY,
  parameter int OPEN_TIMEOUT = 200,
  parameter int CNT_W        = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arrive_i,
  input  logic uni_i,
  input  logic pass_i,
  input  logic vacancy_i,
  output logic barrier_o,
  output logic denied_o,
  output logic uni_o,
  output logic event_req_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OPEN_TIMEOUT - 1);

  logic [2:0]       sync1_q, sync2_q;
  logic             arrive_prev_q;
  logic             arrive_s, uni_s, pass_s;
  gate_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uni_q, uni_d;
  logic             req;

  assign arrive_s = sync2_q[2];
  assign uni_s    = sync2_q[1];
  assign pass_s   = sync2_q[0];

  // Two-flop synchronizers for the field levels, plus arrive history for edge detect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      arrive_prev_q <= 1'b0;
    end else begin
      sync1_q       <= {arrive_i, uni_i, pass_i};
      sync2_q       <= sync1_q;
      arrive_prev_q <= arrive_s;
    end
  end

  // State, timeout counter and latched car class.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      uni_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      uni_q   <= uni_d;
    end
  end

  // Next-state logic; counter only runs while OPEN and is cleared elsewhere.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    uni_d   = uni_q;
    req     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arrive_s && !arrive_prev_q) begin
          uni_d   = uni_s;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!IS_ENTRY || vacancy_i) state_d = S_OPEN;
        else                        state_d = S_DENY;
      end
      S_DENY: begin
        if (!arrive_s)      state_d = S_IDLE;
        else if (vacancy_i) state_d = S_OPEN;
      end
      S_OPEN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (pass_s)                 state_d = S_PASSING;
        else if (cnt_q == CNT_LAST) state_d = S_CLOSE;
      end
      S_PASSING: begin
        if (!pass_s) begin
          req     = 1'b1;
          state_d = S_CLOSE;
        end
      end
      S_CLOSE: begin
        if (!arrive_s && !pass_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign barrier_o   = (state_q == S_OPEN) || (state_q == S_PASSING);
  assign denied_o    = (state_q == S_DENY);
  assign uni_o       = uni_q;
  assign event_req_o = req;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit barrier controller feeding car events to the occupancy counter.
// Holds the vacancy mux and the exit-first event arbiter.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int OPEN_TIMEOUT = 200,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic start,
  input  logic ent_arrive,
  input  logic ent_uni,
  input  logic ent_pass,
  input  logic ext_arrive,
  input  logic ext_uni,
  input  logic ext_pass,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  output logic ent_barrier_open,
  output logic ext_barrier_open,
  output logic ent_denied,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited
);

  logic ent_vac, ent_uni_w, ext_uni_w, ent_req, ext_req;
  logic ent_den_w, ext_den_w;
  logic ent_fire, pend_d, pend_q;
  logic car_entered_q, uni_entered_q, car_exited_q, uni_exited_q;

  assign ent_vac = ent_uni_w ? uni_is_vacated_space : is_vacated_space;

  parking_gate_fsm #(.IS_ENTRY(GATE_ENTRY), .OPEN_TIMEOUT(OPEN_TIMEOUT), .CNT_W(CNT_W)) u_ent (
    .clk_i(clk), .rst_i(start),
    .arrive_i(ent_arrive), .uni_i(ent_uni), .pass_i(ent_pass), .vacancy_i(ent_vac),
    .barrier_o(ent_barrier_open), .denied_o(ent_den_w), .uni_o(ent_uni_w), .event_req_o(ent_req)
  );

  parking_gate_fsm #(.IS_ENTRY(GATE_EXIT), .OPEN_TIMEOUT(OPEN_TIMEOUT), .CNT_W(CNT_W)) u_ext (
    .clk_i(clk), .rst_i(start),
    .arrive_i(ext_arrive), .uni_i(ext_uni), .pass_i(ext_pass), .vacancy_i(1'b1),
    .barrier_o(ext_barrier_open), .denied_o(ext_den_w), .uni_o(ext_uni_w), .event_req_o(ext_req)
  );

  // The exit gate never reaches DENY, so this is effectively the entry flag.
  assign ent_denied = ent_den_w | ext_den_w;

  // Exit wins a same-cycle collision; the entry request waits one cycle.
  always_comb begin
    ent_fire = !ext_req && (pend_q || ent_req);
    pend_d   = ext_req && (pend_q || ent_req);
  end

  // Registered event pulses; tags are forced low outside the pulse.
  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      pend_q        <= 1'b0;
      car_entered_q <= 1'b0;
      uni_entered_q <= 1'b0;
      car_exited_q  <= 1'b0;
      uni_exited_q  <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      car_entered_q <= ent_fire;
      uni_entered_q <= ent_fire & ent_uni_w;
      car_exited_q  <= ext_req;
      uni_exited_q  <= ext_req & ext_uni_w;
    end
  end

  assign car_entered        = car_entered_q;
  assign is_uni_car_entered = uni_entered_q;
  assign car_exited         = car_exited_q;
  assign is_uni_car_exited  = uni_exited_q;

endmodule
